fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Round-robin write-port arbiter that shares one FIFO write interface between NREQ requesters in the write-clock domain.
- Each requester presents beats in bursts.
- The arbiter grants one requester at a time, holds the grant until that burst ends, and drives the FIFO's winc/wdata.
- It throttles all transfers against the FIFO's wfull.

Parameters:
- DSIZE, 8, data width; matches the FIFO DSIZE.
- NREQ, 4, number of requesters, 2..16.
- MAXBURST, 8, maximum beats per grant, 1..256. Forces rearbitration so no requester can hog the port.

Ports:
- wclk  input  1  write-domain clock; all logic rises on posedge.
- wrst  input  1  asynchronous active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last beat of burst; qualified by req_valid.
- req_data  input  NREQ*DSIZE  packed beats; requester i occupies bits [i*DSIZE +: DSIZE].
- req_ready  output  NREQ  per-requester beat accepted this cycle.
- wfull  input  1  FIFO full flag (already registered in the FIFO).
- winc  output  1  FIFO write enable.
- wdata  output  DSIZE  FIFO write data.
- grant  output  NREQ  one-hot current grant; all zero when idle.
- busy  output  1  high in BURST state.

Behaviour:

Reset (wrst=1, takes effect asynchronously):
- state=IDLE, grant=0, rr_ptr=0, beat_cnt=0.
- Outputs are forced to winc=0, req_ready=0, busy=0, wdata=0.

Beat acceptance:
- A beat is accepted when req_valid[i] & req_ready[i].

State IDLE:
- req_ready=0 and winc=0.
- If |req_valid: winner = first set bit of req_valid searching from index rr_ptr upward, wrapping NREQ-1 to 0.
- At the next edge: grant <= onehot(winner), state <= BURST, beat_cnt <= 0.
- Arbitration latency is exactly 1 cycle; there is no transfer in the arbitration cycle.

State BURST, with g = granted index:
- req_ready[g] = ~wfull. All other req_ready bits are 0.
- winc = req_valid[g] & ~wfull (combinational).
- wdata = req_data[g] when grant is nonzero, else 0.
- On an accepted beat: beat_cnt increments.
- If req_last[g] is set, or beat_cnt == MAXBURST-1: state <= IDLE, grant <= 0, rr_ptr <= (g+1) mod NREQ.
- If req_valid[g] is low (bubble) or wfull is high (stall): grant is held, beat_cnt is unchanged, and there is no timeout.
- Non-granted requesters must hold req_valid and their data stable until served.

Boundary conditions:
- Simultaneous requests: lowest index at or after rr_ptr wins.
- rr_ptr wraps NREQ-1 -> 0.
- A one-beat burst with last=1 returns to IDLE after 1 transfer.
- Back-to-back bursts insert exactly 1 IDLE cycle between the last beat and the next grant.
- A MAXBURST cap ends the grant even if req_last was not seen; the requester re-arbitrates for the remainder.
- wfull asserted on the cycle of the last beat: the beat is not accepted and the arbiter stays in BURST.
- Reset mid-burst: the grant is dropped immediately and any partial burst is abandoned. The requester restarts its burst after reset.

Width rules:
- beat_cnt is clog2(MAXBURST)+1 bits.
- rr_ptr is clog2(NREQ) bits; when NREQ is not a power of two it wraps explicitly rather than by overflow.

Test Plan:
- Requester 1 sends 3 beats A1,A2,A3 (last on A3), wfull=0 -> grant=0010 one cycle after req_valid; winc high for 3 consecutive cycles; wdata=A1,A2,A3; then IDLE with rr_ptr=2.
- Requesters 0 and 2 both valid at reset release, 1-beat bursts -> order 0 then 2, then 0 again; 1 idle cycle between each.
- wfull held high for 4 cycles during requester 3's 2-beat burst -> winc=0 and req_ready[3]=0 throughout; beats complete after wfull drops with no data loss or duplication.
- MAXBURST=8, requester 0 streams 10 beats with last only on beat 10 -> grant drops after beat 8; requester 1 (pending) served next; requester 0 resumes for beats 9-10.
- wrst pulsed mid-burst after beat 2 of 5 -> grant=0, winc=0, busy=0 immediately (same cycle, asynchronous); after release, arbitration restarts from rr_ptr=0.
- All four requesters valid continuously with 1-beat bursts -> grants cycle 0,1,2,3,0 with pointer wrap; no requester is starved.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ bursty requesters.
// Grant is held for a whole burst (or MAXBURST beats) and throttled by wfull.
module fifo_wr_arb #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 8
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] grant_nx;
  logic [PW-1:0]   rr_ptr, ptr_nx;
  logic [PW-1:0]   gidx, gidx_nx;
  logic [BW-1:0]   beat_cnt, cnt_nx;
  logic [PW-1:0]   win;
  logic            found;
  int              idx;

  // Rotating priority search starting at rr_ptr; wraps explicitly.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    ptr_nx    = rr_ptr;
    gidx_nx   = gidx;
    cnt_nx    = beat_cnt;
    req_ready = '0;
    winc      = 1'b0;
    busy      = 1'b0;
    wdata     = '0;
    if (|grant)
      wdata = req_data[int'(gidx)*DSIZE +: DSIZE];
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nx      = '0;
          grant_nx[win] = 1'b1;
          gidx_nx       = win;
          state_nx      = BURST;
          cnt_nx        = '0;
        end
      end
      BURST: begin
        busy            = 1'b1;
        req_ready[gidx] = ~wfull;
        winc            = req_valid[gidx] & ~wfull;
        if (winc) begin
          cnt_nx = beat_cnt + 1'b1;
          if (req_last[gidx] || beat_cnt == BW'(MAXBURST - 1)) begin
            state_nx = IDLE;
            grant_nx = '0;
            ptr_nx   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      gidx     <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      rr_ptr   <= ptr_nx;
      gidx     <= gidx_nx;
      beat_cnt <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: arbitration order, bursts, stalls, cap, reset.
module tb_fifo_wr_arb;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [7:0]  d [4];
  logic [31:0] req_data;
  logic        wfull, winc, busy;
  logic [7:0]  wdata;
  int          checks = 0;
  int          failures = 0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  always #5 wclk = ~wclk;

  fifo_wr_arb #(.DSIZE(8), .NREQ(4), .MAXBURST(8)) dut (
    .wclk(wclk), .wrst(wrst),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .wfull(wfull), .winc(winc), .wdata(wdata),
    .grant(grant), .busy(busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    wrst = 1'b1;
    req_valid = '0;
    req_last = '0;
    wfull = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    tick;
    settle;
    chk("rst_grant", grant, 0);
    chk("rst_winc", winc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_wdata", wdata, 0);
    tick;
    wrst = 1'b0;

    // three-beat burst from requester 1
    req_valid = 4'b0010;
    d[1] = 8'hA1;
    settle;
    chk("t1_arb_grant", grant, 0);
    chk("t1_arb_winc", winc, 0);
    tick; settle;
    chk("t1_b1_grant", grant, 4'b0010);
    chk("t1_b1_winc", winc, 1);
    chk("t1_b1_wdata", wdata, 8'hA1);
    chk("t1_b1_ready", req_ready, 4'b0010);
    chk("t1_b1_busy", busy, 1);
    tick; d[1] = 8'hA2; settle;
    chk("t1_b2_winc", winc, 1);
    chk("t1_b2_wdata", wdata, 8'hA2);
    tick; d[1] = 8'hA3; req_last = 4'b0010; settle;
    chk("t1_b3_winc", winc, 1);
    chk("t1_b3_wdata", wdata, 8'hA3);
    tick;
    req_valid = 4'b1001; req_last = 4'b1001;
    d[0] = 8'h0F; d[1] = 8'h00; d[3] = 8'h3F;
    settle;
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_busy", busy, 0);
    tick; settle;
    chk("t1_ptr2_grant", grant, 4'b1000);
    chk("t1_ptr2_wdata", wdata, 8'h3F);
    tick; req_valid = '0; req_last = '0; settle;
    chk("t1_end_grant", grant, 0);

    // requesters 0 and 2 from reset, one-beat bursts
    wrst = 1'b1;
    req_valid = 4'b0101; req_last = 4'b0101;
    d[0] = 8'h10; d[2] = 8'h20;
    settle;
    chk("t2_rst_grant", grant, 0);
    tick; wrst = 1'b0; settle;
    chk("t2_arb_grant", grant, 0);
    tick; settle;
    chk("t2_g0_grant", grant, 4'b0001);
    chk("t2_g0_wdata", wdata, 8'h10);
    tick; settle;
    chk("t2_gap1", grant, 0);
    tick; settle;
    chk("t2_g2_grant", grant, 4'b0100);
    chk("t2_g2_wdata", wdata, 8'h20);
    tick; settle;
    chk("t2_gap2", grant, 0);
    tick; settle;
    chk("t2_g0b_grant", grant, 4'b0001);
    tick; req_valid = '0; req_last = '0; settle;
    chk("t2_end_grant", grant, 0);

    // wfull stall during requester 3's two-beat burst
    req_valid = 4'b1000; d[3] = 8'h31; wfull = 1'b1;
    settle;
    chk("t3_arb_grant", grant, 0);
    for (int i = 0; i < 4; i++) begin
      tick; settle;
      chk("t3_stall_grant", grant, 4'b1000);
      chk("t3_stall_winc", winc, 0);
      chk("t3_stall_ready", req_ready, 0);
    end
    tick; wfull = 1'b0; settle;
    chk("t3_b1_winc", winc, 1);
    chk("t3_b1_wdata", wdata, 8'h31);
    chk("t3_b1_ready", req_ready, 4'b1000);
    tick; d[3] = 8'h32; req_last = 4'b1000; wfull = 1'b1; settle;
    chk("t3_lastfull_winc", winc, 0);
    tick; wfull = 1'b0; settle;
    chk("t3_lastfull_grant", grant, 4'b1000);
    chk("t3_b2_winc", winc, 1);
    chk("t3_b2_wdata", wdata, 8'h32);
    tick; req_valid = '0; req_last = '0; settle;
    chk("t3_end_grant", grant, 0);

    // MAXBURST cap on requester 0, requester 1 pending
    req_valid = 4'b0011; req_last = 4'b0010;
    d[1] = 8'hB1; d[0] = 8'h01;
    settle;
    chk("t4_arb_grant", grant, 0);
    for (int i = 1; i <= 8; i++) begin
      tick; d[0] = 8'(i); settle;
      chk("t4_cap_grant", grant, 4'b0001);
      chk("t4_cap_wdata", wdata, i);
    end
    tick; d[0] = 8'h09; settle;
    chk("t4_capped_grant", grant, 0);
    tick; settle;
    chk("t4_r1_grant", grant, 4'b0010);
    chk("t4_r1_wdata", wdata, 8'hB1);
    tick; req_valid = 4'b0001; req_last = '0; settle;
    chk("t4_gap_grant", grant, 0);
    tick; settle;
    chk("t4_b9_grant", grant, 4'b0001);
    chk("t4_b9_wdata", wdata, 8'h09);
    tick; d[0] = 8'h0A; req_last = 4'b0001; settle;
    chk("t4_b10_wdata", wdata, 8'h0A);
    tick; req_valid = '0; req_last = '0; settle;
    chk("t4_end_grant", grant, 0);

    // asynchronous reset mid-burst
    req_valid = 4'b0100; d[2] = 8'h51;
    settle;
    tick; settle;
    chk("t5_b1_grant", grant, 4'b0100);
    chk("t5_b1_wdata", wdata, 8'h51);
    tick; d[2] = 8'h52; settle;
    chk("t5_b2_wdata", wdata, 8'h52);
    tick; d[2] = 8'h53; settle;
    chk("t5_b3_winc", winc, 1);
    wrst = 1'b1;
    settle;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_winc", winc, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_wdata", wdata, 0);
    tick;
    wrst = 1'b0;
    req_valid = 4'b0101; req_last = 4'b0001;
    d[0] = 8'h60; d[2] = 8'h51;
    settle;
    chk("t5_arb_grant", grant, 0);
    tick; settle;
    chk("t5_ptr0_grant", grant, 4'b0001);
    chk("t5_ptr0_wdata", wdata, 8'h60);
    tick; req_valid = 4'b0100; req_last = '0; settle;
    chk("t5_gap_grant", grant, 0);
    tick; settle;
    chk("t5_restart_grant", grant, 4'b0100);
    chk("t5_restart_wdata", wdata, 8'h51);

    // all four valid, one-beat bursts, pointer wrap
    wrst = 1'b1;
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 8'hC0 + 8'(i);
    tick;
    wrst = 1'b0;
    settle;
    for (int k = 0; k < 5; k++) begin
      chk("t6_idle_grant", grant, 0);
      tick; settle;
      chk("t6_rr_grant", grant, 32'd1 << (k % 4));
      chk("t6_rr_wdata", wdata, 8'hC0 + 8'(k % 4));
      tick; settle;
    end
    req_valid = '0; req_last = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
